ddr_cmd_arbiter: RTL and testbench

- Shares the single DDR3 controller command port between the AXI write-path (store/accept) and the AXI read-path (fetch/accept).
- Read-priority round-robin, with a write-starvation limit and a read-after-write block-address hazard check.
- After granting a write, holds the port until the write-data burst (snooped) has completed.
- Sits between the AXI write/read paths and the DDR3 controller front-end.

---
 rtl/ddr_cmd_arbiter_pkg.sv | 14 +
 rtl/ddr_cmd_arbiter_if.sv | 39 +++
 rtl/ddr_cmd_arbiter_arb_policy.sv | 58 +++++
 rtl/ddr_cmd_arbiter.sv | 94 +++++++++
 tb/tb_ddr_cmd_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_cmd_arbiter_pkg.sv
// Shared types and constants for the DDR3 command-port arbiter.
package ddr_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WCMD = 2'd1,
    ST_WDAT = 2'd2,
    ST_RCMD = 2'd3
  } arb_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// Bundle of the write-path, read-path, data-snoop and controller command signals.
interface ddr_cmd_arbiter_if #(
  parameter int ADDRS        = 32,
  parameter int AXI_ID_WIDTH = 4
);
  // Handshakes: a requester raises wr_store_i / rd_fetch_i with stable id/addr and holds it
  // until the one-cycle accept pulse; a command moves to the controller in any cycle with
  // ctl_valid_o & ctl_ready_i, and ctl_* stay stable while ctl_valid_o is high and ready is low.
  logic                    wr_store_i;
  logic                    wr_accept_o;
  logic [AXI_ID_WIDTH-1:0] wr_wrid_i;
  logic [ADDRS-1:0]        wr_addr_i;
  logic                    wr_dvalid_i;
  logic                    wr_dready_i;
  logic                    wr_dlast_i;
  logic                    rd_fetch_i;
  logic                    rd_accept_o;
  logic [AXI_ID_WIDTH-1:0] rd_rdid_i;
  logic [ADDRS-1:0]        rd_addr_i;
  logic                    ctl_valid_o;
  logic                    ctl_ready_i;
  logic                    ctl_write_o;
  logic [AXI_ID_WIDTH-1:0] ctl_id_o;
  logic [ADDRS-1:0]        ctl_addr_o;
  logic                    arb_err_o;

  modport slave (
    input  wr_store_i, wr_wrid_i, wr_addr_i, wr_dvalid_i, wr_dready_i, wr_dlast_i,
    input  rd_fetch_i, rd_rdid_i, rd_addr_i, ctl_ready_i,
    output wr_accept_o, rd_accept_o, ctl_valid_o, ctl_write_o, ctl_id_o, ctl_addr_o, arb_err_o
  );

  modport master (
    output wr_store_i, wr_wrid_i, wr_addr_i, wr_dvalid_i, wr_dready_i, wr_dlast_i,
    output rd_fetch_i, rd_rdid_i, rd_addr_i, ctl_ready_i,
    input  wr_accept_o, rd_accept_o, ctl_valid_o, ctl_write_o, ctl_id_o, ctl_addr_o, arb_err_o
  );

endinterface

// File: rtl/ddr_cmd_arbiter_arb_policy.sv
// Grant decision for the idle state: reads win unless hazard, write starvation or read-run limit.
module arb_policy
  import ddr_cmd_arbiter_pkg::*;
#(
  parameter int BLK_W        = 25,
  parameter int WR_MAX_WAIT  = 16,
  parameter int RD_BURST_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  arb_state_e       state,
  input  logic             wr_store,
  input  logic             rd_fetch,
  input  logic [BLK_W-1:0] wr_blk,
  input  logic [BLK_W-1:0] rd_blk,
  output logic             grant_wr,
  output logic             grant_rd
);

  localparam int WW = $clog2(WR_MAX_WAIT + 1);
  localparam int RW = $clog2(RD_BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(WR_MAX_WAIT);
  localparam logic [RW-1:0] RUN_SAT  = RW'(RD_BURST_MAX);

  logic [WW-1:0] wr_wait;
  logic [RW-1:0] rd_run;
  logic          in_idle;
  logic          force_wr;

  always_comb begin
    in_idle  = (state == ST_IDLE);
    force_wr = (rd_blk == wr_blk) || (wr_wait >= WAIT_SAT) || (rd_run >= RUN_SAT);
    grant_wr = in_idle && wr_store && (!rd_fetch || force_wr);
    grant_rd = in_idle && rd_fetch && !grant_wr;
  end

  // wr_wait counts cycles a pending write is bypassed while the port is free or serving a read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_wait <= '0;
      rd_run  <= '0;
    end else begin
      if (grant_wr || !wr_store)
        wr_wait <= '0;
      else if ((in_idle || state == ST_RCMD) && wr_wait != WAIT_SAT)
        wr_wait <= wr_wait + WW'(1);

      if (grant_wr)
        rd_run <= '0;
      else if (grant_rd) begin
        if (rd_run != RUN_SAT)
          rd_run <= rd_run + RW'(1);
      end else if (in_idle && !rd_fetch)
        rd_run <= '0;
    end
  end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Shares the DDR3 controller command port between the AXI write and read paths.
module ddr_cmd_arbiter
  import ddr_cmd_arbiter_pkg::*;
#(
  parameter int ADDRS        = 32,
  parameter int AXI_ID_WIDTH = 4,
  parameter int BLOCK_BITS   = 7,
  parameter int WR_MAX_WAIT  = 16,
  parameter int RD_BURST_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  ddr_cmd_arbiter_if.slave    bus,
  output arb_state_e          dbg_state
);

  arb_state_e              state_q, state_d;
  logic                    valid_q;
  logic                    write_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [ADDRS-1:0]        addr_q;
  logic                    err_q;
  logic                    grant_wr, grant_rd;
  logic                    cmd_hs, last_hs, proto_err;

  arb_policy #(
    .BLK_W        (ADDRS - BLOCK_BITS),
    .WR_MAX_WAIT  (WR_MAX_WAIT),
    .RD_BURST_MAX (RD_BURST_MAX)
  ) u_policy (
    .clock    (clock),
    .reset    (reset),
    .state    (state_q),
    .wr_store (bus.wr_store_i),
    .rd_fetch (bus.rd_fetch_i),
    .wr_blk   (bus.wr_addr_i[ADDRS-1:BLOCK_BITS]),
    .rd_blk   (bus.rd_addr_i[ADDRS-1:BLOCK_BITS]),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  always_comb begin
    cmd_hs    = valid_q && bus.ctl_ready_i;
    last_hs   = bus.wr_dvalid_i && bus.wr_dready_i && bus.wr_dlast_i;
    proto_err = (last_hs && state_q != ST_WDAT) ||
                (state_q == ST_WCMD && !bus.wr_store_i) ||
                (state_q == ST_RCMD && !bus.rd_fetch_i);
    state_d   = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_wr) state_d = ST_WCMD;
               else if (grant_rd) state_d = ST_RCMD;
      ST_WCMD: if (cmd_hs) state_d = ST_WDAT;
      ST_WDAT: if (last_hs) state_d = ST_IDLE;
      ST_RCMD: if (cmd_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Grants only happen in idle, when valid_q is low, so a grant and a handshake never coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      write_q <= CMD_READ;
      id_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant_wr || grant_rd) begin
        valid_q <= 1'b1;
        write_q <= grant_wr ? CMD_WRITE : CMD_READ;
        id_q    <= grant_wr ? bus.wr_wrid_i : bus.rd_rdid_i;
        addr_q  <= grant_wr ? bus.wr_addr_i : bus.rd_addr_i;
      end else if (cmd_hs) begin
        valid_q <= 1'b0;
      end
      if (proto_err) err_q <= 1'b1;
    end
  end

  assign bus.ctl_valid_o = valid_q;
  assign bus.ctl_write_o = write_q;
  assign bus.ctl_id_o    = id_q;
  assign bus.ctl_addr_o  = addr_q;
  assign bus.arb_err_o   = err_q;
  assign bus.wr_accept_o = cmd_hs && (write_q == CMD_WRITE);
  assign bus.rd_accept_o = cmd_hs && (write_q == CMD_READ);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed and randomized bench for ddr_cmd_arbiter with a cycle-level reference model.
module tb_ddr_cmd_arbiter;

  localparam int AW     = 32;
  localparam int IW     = 4;
  localparam int BB     = 7;
  localparam int WR_MAX = 16;
  localparam int RD_MAX = 4;

  logic       clock;
  logic       reset;
  logic [1:0] a_state, b_state;
  int         n_checks = 0;
  int         n_errors = 0;

  ddr_cmd_arbiter_if #(.ADDRS(AW), .AXI_ID_WIDTH(IW)) a_if ();
  ddr_cmd_arbiter_if #(.ADDRS(AW), .AXI_ID_WIDTH(IW)) b_if ();

  ddr_cmd_arbiter #(.RD_BURST_MAX(RD_MAX)) dut_a (
    .clock(clock), .reset(reset), .bus(a_if.slave), .dbg_state(a_state));
  ddr_cmd_arbiter #(.RD_BURST_MAX(64)) dut_b (
    .clock(clock), .reset(reset), .bus(b_if.slave), .dbg_state(b_state));

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (dut_a) ----------------
  // The port is either free, carrying one presented command, or waiting out a write burst.
  logic          m_valid, m_write, m_burst, m_err;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  int            m_wait, m_run;

  always @(negedge clock) begin : ref_model
    logic free, ws, rf, dhs, force_w, g_w, g_r;
    if (!reset) begin
      m_valid = 0; m_write = 0; m_burst = 0; m_err = 0;
      m_id = '0; m_addr = '0; m_wait = 0; m_run = 0;
      check("rst_valid", a_if.ctl_valid_o, 0);
      check("rst_write", a_if.ctl_write_o, 0);
      check("rst_addr",  a_if.ctl_addr_o, 0);
      check("rst_id",    a_if.ctl_id_o, 0);
      check("rst_err",   a_if.arb_err_o, 0);
      check("rst_acc",   {a_if.wr_accept_o, a_if.rd_accept_o}, 0);
    end else begin
      check("m_valid", a_if.ctl_valid_o, m_valid);
      check("m_write", a_if.ctl_write_o, m_write);
      check("m_id",    a_if.ctl_id_o, m_id);
      check("m_addr",  a_if.ctl_addr_o, m_addr);
      check("m_err",   a_if.arb_err_o, m_err);
      check("m_wacc",  a_if.wr_accept_o, m_valid && a_if.ctl_ready_i && m_write);
      check("m_racc",  a_if.rd_accept_o, m_valid && a_if.ctl_ready_i && !m_write);

      free    = !m_valid && !m_burst;
      ws      = a_if.wr_store_i;
      rf      = a_if.rd_fetch_i;
      dhs     = a_if.wr_dvalid_i && a_if.wr_dready_i && a_if.wr_dlast_i;
      force_w = ((a_if.wr_addr_i >> BB) == (a_if.rd_addr_i >> BB)) ||
                (m_wait >= WR_MAX) || (m_run >= RD_MAX);
      g_w     = free && ws && (!rf || force_w);
      g_r     = free && rf && !g_w;

      if ((dhs && !m_burst) || (m_valid && m_write && !ws) || (m_valid && !m_write && !rf))
        m_err = 1;

      if (g_w || !ws) m_wait = 0;
      else if (free || (m_valid && !m_write)) m_wait = (m_wait + 1 > WR_MAX) ? WR_MAX : m_wait + 1;

      if (g_w) m_run = 0;
      else if (g_r) m_run = (m_run + 1 > RD_MAX) ? RD_MAX : m_run + 1;
      else if (free && !rf) m_run = 0;

      if (g_w || g_r) begin
        m_valid = 1;
        m_write = g_w;
        m_id    = g_w ? a_if.wr_wrid_i : a_if.rd_rdid_i;
        m_addr  = g_w ? a_if.wr_addr_i : a_if.rd_addr_i;
      end else if (m_valid && a_if.ctl_ready_i) begin
        m_valid = 0;
        if (m_write) m_burst = 1;
      end else if (m_burst && dhs) begin
        m_burst = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    a_if.wr_store_i = 0; a_if.wr_wrid_i = '0; a_if.wr_addr_i = '0;
    a_if.wr_dvalid_i = 0; a_if.wr_dready_i = 0; a_if.wr_dlast_i = 0;
    a_if.rd_fetch_i = 0; a_if.rd_rdid_i = '0; a_if.rd_addr_i = '0; a_if.ctl_ready_i = 1;
    b_if.wr_store_i = 0; b_if.wr_wrid_i = '0; b_if.wr_addr_i = '0;
    b_if.wr_dvalid_i = 0; b_if.wr_dready_i = 0; b_if.wr_dlast_i = 0;
    b_if.rd_fetch_i = 0; b_if.rd_rdid_i = '0; b_if.rd_addr_i = '0; b_if.ctl_ready_i = 1;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return (AW'($urandom_range(0, 15)) << BB) | AW'($urandom_range(0, 127));
  endfunction

  bit w_pend, r_pend;
  int beats;

  task automatic rand_cycle(input bit allow_new);
    step();
    if (!w_pend && allow_new && $urandom_range(0, 3) == 0) begin
      w_pend = 1;
      a_if.wr_wrid_i = IW'($urandom);
      a_if.wr_addr_i = rand_addr();
    end
    if (!r_pend && allow_new && $urandom_range(0, 2) == 0) begin
      r_pend = 1;
      a_if.rd_rdid_i = IW'($urandom);
      a_if.rd_addr_i = rand_addr();
    end
    a_if.wr_store_i  = w_pend;
    a_if.rd_fetch_i  = r_pend;
    a_if.wr_dvalid_i = (beats > 0) && ($urandom_range(0, 1) == 1);
    a_if.wr_dlast_i  = a_if.wr_dvalid_i && (beats == 1);
    a_if.wr_dready_i = ($urandom_range(0, 1) == 1);
    a_if.ctl_ready_i = ($urandom_range(0, 3) != 0);
    @(negedge clock);
    if (beats > 0 && a_if.wr_dvalid_i && a_if.wr_dready_i) beats--;
    if (a_if.wr_accept_o) begin
      w_pend = 0;
      beats  = $urandom_range(1, 4);
    end
    if (a_if.rd_accept_o) r_pend = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  a_reads, b_reads;
    bit  a_done, b_done;
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    check("rst_state", a_state, 2'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) step();

    // Single write, then a read that must wait for the whole data burst.
    a_if.wr_store_i = 1; a_if.wr_wrid_i = 4'd3; a_if.wr_addr_i = 32'h100;
    @(negedge clock);
    check("w1_valid_lat", a_if.ctl_valid_o, 0);
    step();
    a_if.rd_fetch_i = 1; a_if.rd_rdid_i = 4'd5; a_if.rd_addr_i = 32'h8000;
    @(negedge clock);
    check("w1_valid",  a_if.ctl_valid_o, 1);
    check("w1_write",  a_if.ctl_write_o, 1);
    check("w1_addr",   a_if.ctl_addr_o, 32'h100);
    check("w1_id",     a_if.ctl_id_o, 4'd3);
    check("w1_wacc",   a_if.wr_accept_o, 1);
    for (int b = 0; b < 4; b++) begin
      step();
      a_if.wr_store_i = 0;
      a_if.wr_dvalid_i = 1; a_if.wr_dready_i = 1; a_if.wr_dlast_i = (b == 3);
      @(negedge clock);
      check("w1_rd_held", a_if.ctl_valid_o, 0);
      check("w1_wdat",    a_state, 2'd2);
    end
    step();
    a_if.wr_dvalid_i = 0; a_if.wr_dlast_i = 0;
    @(negedge clock);
    check("w1_idle", a_state, 2'd0);
    @(negedge clock);
    check("w1_rd_grant", a_if.rd_accept_o, 1);
    check("w1_rd_addr",  a_if.ctl_addr_o, 32'h8000);
    step();
    a_if.rd_fetch_i = 0; a_if.wr_dready_i = 0;
    repeat (2) step();

    // Write starvation: limit by read run (dut_a) and by wait count (dut_b).
    a_if.wr_store_i = 1; a_if.wr_wrid_i = 4'd7; a_if.wr_addr_i = 32'h4000;
    a_if.rd_fetch_i = 1; a_if.rd_rdid_i = 4'd2; a_if.rd_addr_i = 32'h2000;
    b_if.wr_store_i = 1; b_if.wr_wrid_i = 4'd7; b_if.wr_addr_i = 32'h4000;
    b_if.rd_fetch_i = 1; b_if.rd_rdid_i = 4'd2; b_if.rd_addr_i = 32'h2000;
    a_reads = 0; b_reads = 0; a_done = 0; b_done = 0;
    for (int c = 0; c < 60 && !(a_done && b_done); c++) begin
      @(negedge clock);
      if (!a_done) begin
        if (a_if.rd_accept_o) a_reads++;
        if (a_if.wr_accept_o) a_done = 1;
      end
      if (!b_done) begin
        if (b_if.rd_accept_o) b_reads++;
        if (b_if.wr_accept_o) b_done = 1;
      end
      step();
      if (a_done) a_if.wr_store_i = 0;
      if (b_done) b_if.wr_store_i = 0;
    end
    check("starve_a_done", a_done, 1);
    check("starve_b_done", b_done, 1);
    check("starve_a_reads", a_reads, RD_MAX);
    check("starve_b_reads", b_reads, WR_MAX / 2);
    a_if.rd_fetch_i = 0; b_if.rd_fetch_i = 0;
    a_if.wr_dvalid_i = 1; a_if.wr_dready_i = 1; a_if.wr_dlast_i = 1;
    step();
    a_if.wr_dvalid_i = 0; a_if.wr_dready_i = 0; a_if.wr_dlast_i = 0;
    repeat (2) step();

    // Read-after-write hazard within one 128-byte block.
    a_if.wr_store_i = 1; a_if.wr_wrid_i = 4'd1; a_if.wr_addr_i = 32'h1000;
    a_if.rd_fetch_i = 1; a_if.rd_rdid_i = 4'd9; a_if.rd_addr_i = 32'h1040;
    @(negedge clock);
    @(negedge clock);
    check("haz_wacc", a_if.wr_accept_o, 1);
    check("haz_racc", a_if.rd_accept_o, 0);
    step();
    a_if.wr_store_i = 0;
    a_if.wr_dvalid_i = 1; a_if.wr_dready_i = 1; a_if.wr_dlast_i = 1;
    @(negedge clock);
    check("haz_rd_wait", a_if.ctl_valid_o, 0);
    step();
    a_if.wr_dvalid_i = 0; a_if.wr_dready_i = 0; a_if.wr_dlast_i = 0;
    @(negedge clock);
    @(negedge clock);
    check("haz_rd_acc",  a_if.rd_accept_o, 1);
    check("haz_rd_addr", a_if.ctl_addr_o, 32'h1040);
    step();
    a_if.rd_fetch_i = 0;
    repeat (2) step();

    // Controller stalls a read command for 10 cycles.
    a_if.ctl_ready_i = 0;
    a_if.rd_fetch_i = 1; a_if.rd_rdid_i = 4'd6; a_if.rd_addr_i = 32'h3000;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_valid", a_if.ctl_valid_o, 1);
      check("stall_addr",  a_if.ctl_addr_o, 32'h3000);
      check("stall_id",    a_if.ctl_id_o, 4'd6);
      check("stall_racc",  a_if.rd_accept_o, 0);
    end
    step();
    a_if.ctl_ready_i = 1;
    @(negedge clock);
    check("stall_release", a_if.rd_accept_o, 1);
    step();
    a_if.rd_fetch_i = 0;
    repeat (2) step();

    // Randomized traffic, then drain outstanding work.
    w_pend = 0; r_pend = 0; beats = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1);
    for (int c = 0; c < 400 && (w_pend || r_pend || beats > 0); c++) rand_cycle(0);
    check("rand_drained", {w_pend, r_pend, beats > 0}, 0);
    step();
    idle_inputs();
    repeat (3) step();

    // Reset in the middle of a write-data burst.
    a_if.wr_store_i = 1; a_if.wr_wrid_i = 4'd4; a_if.wr_addr_i = 32'h500;
    @(negedge clock);
    @(negedge clock);
    check("rmid_wacc", a_if.wr_accept_o, 1);
    step();
    a_if.wr_store_i = 0;
    #2 reset = 1'b0;
    #1;
    check("rmid_valid", a_if.ctl_valid_o, 0);
    check("rmid_addr",  a_if.ctl_addr_o, 0);
    check("rmid_id",    a_if.ctl_id_o, 0);
    check("rmid_write", a_if.ctl_write_o, 0);
    check("rmid_state", a_state, 2'd0);
    step();
    reset = 1'b1;
    step();
    a_if.rd_fetch_i = 1; a_if.rd_rdid_i = 4'd8; a_if.rd_addr_i = 32'h600;
    @(negedge clock);
    @(negedge clock);
    check("rpost_valid", a_if.ctl_valid_o, 1);
    check("rpost_write", a_if.ctl_write_o, 0);
    check("rpost_addr",  a_if.ctl_addr_o, 32'h600);
    check("rpost_racc",  a_if.rd_accept_o, 1);
    step();
    a_if.rd_fetch_i = 0;
    repeat (2) step();

    // Last-beat handshake while idle is a sticky protocol error.
    a_if.wr_dvalid_i = 1; a_if.wr_dready_i = 1; a_if.wr_dlast_i = 1;
    step();
    a_if.wr_dvalid_i = 0; a_if.wr_dready_i = 0; a_if.wr_dlast_i = 0;
    @(negedge clock);
    check("err_set", a_if.arb_err_o, 1);
    repeat (5) step();
    @(negedge clock);
    check("err_sticky", a_if.arb_err_o, 1);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("err_cleared", a_if.arb_err_o, 0);
    step();
    reset = 1'b1;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
